range_lookup_engine: RTL and testbench
======================================

Name: range_lookup_engine

Overview:
- Read-side engine for the allocation range buffer. The allocation path writes {first,last} address pairs into that buffer; this block reads them.
- It accepts lookup or free requests through a valid/ready handshake and scans buffer entries through a 1-cycle-latency read port.
- It returns hit/miss, the matching index and the matching range. On a matching free request it pulses an invalidate for the matching entry.
- It sits between the load/store bounds-check logic and the range buffer.

Parameters:
- SIZE, 8, number of entries in the range buffer (power of two, 2..64).
- IDX_W, $clog2(SIZE), width of the entry index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_free_i  in  1  0 = lookup, 1 = free (invalidate matching base)
- req_addr_i  in  32  address to check or base address to free
- buf_rd_en_o  out  1  buffer read strobe
- buf_rd_idx_o  out  IDX_W  buffer read index
- buf_rd_data_i  in  64  {first[63:32], last[31:0]}; valid the cycle after rd_en
- buf_wr_seen_i  in  1  buffer written this cycle (allocation path)
- buf_clr_o  out  1  invalidate strobe
- buf_clr_idx_o  out  IDX_W  index to invalidate
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&ready
- resp_hit_o  out  1  match found
- resp_idx_o  out  IDX_W  matching index (0 on miss)
- resp_first_o  out  32  matched first address (0 on miss)
- resp_last_o  out  32  matched last address (0 on miss)

Behaviour:
- Reset:
  - All outputs 0, state IDLE, counters 0.
  - Reset mid-scan aborts the request with no response and no clear.
- States:
  - IDLE: req_ready_o=1. Accepting a request latches addr and free, then moves to SCAN.
  - SCAN: each cycle with the issue counter c < SIZE, drives rd_en=1 and rd_idx=c, then c++.
    - The compare stage checks buf_rd_data_i for the index issued the previous cycle.
    - An all-zero 64-bit entry is empty and never matches.
  - RESP: response outputs are registered and held stable until resp_ready_i. The handshake then returns to IDLE.
- Matching:
  - Lookup match when first <= addr <= last, unsigned and inclusive.
  - Free match when addr == first exactly.
- Termination:
  - The first (lowest-index) match ends the scan and moves to RESP.
  - One speculative read issued in the hit cycle is harmless.
  - No match after the compare of index SIZE-1 moves to RESP with hit=0.
- Latency: acceptance edge = cycle 0. A hit at index k gives resp_valid in cycle k+3. A miss gives resp_valid in cycle SIZE+2.
- Free hit:
  - buf_clr_o=1 with buf_clr_idx_o=k for exactly the first cycle of RESP, independent of resp_ready_i.
  - A free miss produces no clear.
- Buffer written during SCAN (buf_wr_seen_i=1): discard in-flight compare results and restart issue from index 0 next cycle. Restarts are unbounded.
- buf_wr_seen_i in IDLE or RESP has no effect.
- req_valid_i is ignored outside IDLE. Only one request is in flight.
- buf_rd_en_o=0 outside SCAN.

Optional Feature:
- Macro RANGE_LOOKUP_STATS_EN.
- When defined, adds outputs stat_hits_o[31:0], stat_misses_o[31:0] and stat_restarts_o[15:0].
  - Each increments once per completed lookup or free response, or once per restart.
  - Each saturates at its maximum and resets to 0.
- When not defined, these ports and their counters do not exist. Core behaviour is identical either way.

Test Plan:
- Entry 2={0x1000,0x10FF}, others 0; lookup 0x1080 -> resp in cycle 5: hit=1, idx=2, first=0x1000, last=0x10FF; no clear.
- Same table; lookup 0x1100 -> resp in cycle 10 (SIZE=8): hit=0, idx=0, first=0, last=0.
- Entries 1={0x2000,0x20FF} and 4={0x2000,0x2FFF}; lookup 0x2010 -> hit idx=1 (lowest wins).
- Entry 3={0x3000,0x30FF}; free 0x3000 -> hit, buf_clr_o one cycle with idx=3. Free 0x3004 -> miss, no clear.
- Lookup running, buf_wr_seen_i pulsed in cycle 3 -> rd_idx returns to 0 in cycle 4. Response then arrives relative to the restart. With stats enabled, stat_restarts=1.
- Response held with resp_ready_i=0 for 5 cycles -> outputs stable, req_ready_o=0. rst_ni low mid-SCAN -> all outputs 0, no response afterwards.

Source files
------------

// File: rtl/range_lookup_engine.sv
// rtl/range_lookup_engine.sv - scans the allocation range buffer for lookup/free matches
// Optional statistics outputs are enabled by defining RANGE_LOOKUP_STATS_EN.
module range_lookup_engine #(
    parameter int SIZE  = 8,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_free_i,
    input  logic [31:0]      req_addr_i,
    output logic             buf_rd_en_o,
    output logic [IDX_W-1:0] buf_rd_idx_o,
    input  logic [63:0]      buf_rd_data_i,
    input  logic             buf_wr_seen_i,
    output logic             buf_clr_o,
    output logic [IDX_W-1:0] buf_clr_idx_o,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_hit_o,
    output logic [IDX_W-1:0] resp_idx_o,
    output logic [31:0]      resp_first_o,
    output logic [31:0]      resp_last_o
`ifdef RANGE_LOOKUP_STATS_EN
    ,
    output logic [31:0]      stat_hits_o,
    output logic [31:0]      stat_misses_o,
    output logic [15:0]      stat_restarts_o
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t           state;
    logic [IDX_W:0]   issue_cnt;
    logic             cmp_valid;
    logic [IDX_W-1:0] cmp_idx;
    logic [31:0]      addr_q;
    logic             free_q;

    logic [31:0] entry_first;
    logic [31:0] entry_last;
    logic        entry_match;
    logic        cmp_hit;
    logic        cmp_end;

    assign entry_first = buf_rd_data_i[63:32];
    assign entry_last  = buf_rd_data_i[31:0];

    always_comb begin
        entry_match = 1'b0;
        if (buf_rd_data_i != 64'd0) begin
            if (free_q)
                entry_match = (addr_q == entry_first);
            else
                entry_match = (entry_first <= addr_q) && (addr_q <= entry_last);
        end
    end

    // A buffer write in the same cycle invalidates whatever is being compared.
    assign cmp_hit = cmp_valid && entry_match && !buf_wr_seen_i;
    assign cmp_end = cmp_valid && (cmp_idx == IDX_W'(SIZE - 1)) && !buf_wr_seen_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            issue_cnt     <= '0;
            cmp_valid     <= 1'b0;
            cmp_idx       <= '0;
            addr_q        <= '0;
            free_q        <= 1'b0;
            req_ready_o   <= 1'b0;
            buf_rd_en_o   <= 1'b0;
            buf_rd_idx_o  <= '0;
            buf_clr_o     <= 1'b0;
            buf_clr_idx_o <= '0;
            resp_valid_o  <= 1'b0;
            resp_hit_o    <= 1'b0;
            resp_idx_o    <= '0;
            resp_first_o  <= '0;
            resp_last_o   <= '0;
`ifdef RANGE_LOOKUP_STATS_EN
            stat_hits_o     <= '0;
            stat_misses_o   <= '0;
            stat_restarts_o <= '0;
`endif
        end else begin
            buf_clr_o     <= 1'b0;
            buf_clr_idx_o <= '0;
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        addr_q      <= req_addr_i;
                        free_q      <= req_free_i;
                        issue_cnt   <= '0;
                        cmp_valid   <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (buf_wr_seen_i) begin
                        buf_rd_en_o  <= 1'b1;
                        buf_rd_idx_o <= '0;
                        issue_cnt    <= (IDX_W+1)'(1);
                        cmp_valid    <= 1'b0;
`ifdef RANGE_LOOKUP_STATS_EN
                        if (stat_restarts_o != '1)
                            stat_restarts_o <= stat_restarts_o + 16'd1;
`endif
                    end else if (cmp_hit || cmp_end) begin
                        state        <= RESP;
                        buf_rd_en_o  <= 1'b0;
                        cmp_valid    <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_hit_o   <= cmp_hit;
                        resp_idx_o   <= cmp_hit ? cmp_idx : '0;
                        resp_first_o <= cmp_hit ? entry_first : 32'd0;
                        resp_last_o  <= cmp_hit ? entry_last : 32'd0;
                        if (cmp_hit && free_q) begin
                            buf_clr_o     <= 1'b1;
                            buf_clr_idx_o <= cmp_idx;
                        end
                    end else begin
                        if (issue_cnt < (IDX_W+1)'(SIZE)) begin
                            buf_rd_en_o  <= 1'b1;
                            buf_rd_idx_o <= issue_cnt[IDX_W-1:0];
                            issue_cnt    <= issue_cnt + (IDX_W+1)'(1);
                        end else begin
                            buf_rd_en_o <= 1'b0;
                        end
                        cmp_valid <= buf_rd_en_o;
                        cmp_idx   <= buf_rd_idx_o;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        req_ready_o  <= 1'b1;
                        resp_valid_o <= 1'b0;
                        resp_hit_o   <= 1'b0;
                        resp_idx_o   <= '0;
                        resp_first_o <= '0;
                        resp_last_o  <= '0;
`ifdef RANGE_LOOKUP_STATS_EN
                        if (resp_hit_o && stat_hits_o != '1)
                            stat_hits_o <= stat_hits_o + 32'd1;
                        if (!resp_hit_o && stat_misses_o != '1)
                            stat_misses_o <= stat_misses_o + 32'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_lookup_engine.sv
// tb/tb_range_lookup_engine.sv - scoreboard bench for range_lookup_engine
// Optional statistics ports follow RANGE_LOOKUP_STATS_EN.
module tb_range_lookup_engine;

    localparam int SIZE  = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_free_i;
    logic [31:0]      req_addr_i;
    logic             buf_rd_en_o;
    logic [IDX_W-1:0] buf_rd_idx_o;
    logic [63:0]      buf_rd_data_i;
    logic             buf_wr_seen_i;
    logic             buf_clr_o;
    logic [IDX_W-1:0] buf_clr_idx_o;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic             resp_hit_o;
    logic [IDX_W-1:0] resp_idx_o;
    logic [31:0]      resp_first_o;
    logic [31:0]      resp_last_o;
`ifdef RANGE_LOOKUP_STATS_EN
    logic [31:0]      stat_hits_o;
    logic [31:0]      stat_misses_o;
    logic [15:0]      stat_restarts_o;
`endif

    range_lookup_engine #(.SIZE(SIZE), .IDX_W(IDX_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_free_i    (req_free_i),
        .req_addr_i    (req_addr_i),
        .buf_rd_en_o   (buf_rd_en_o),
        .buf_rd_idx_o  (buf_rd_idx_o),
        .buf_rd_data_i (buf_rd_data_i),
        .buf_wr_seen_i (buf_wr_seen_i),
        .buf_clr_o     (buf_clr_o),
        .buf_clr_idx_o (buf_clr_idx_o),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_hit_o    (resp_hit_o),
        .resp_idx_o    (resp_idx_o),
        .resp_first_o  (resp_first_o),
        .resp_last_o   (resp_last_o)
`ifdef RANGE_LOOKUP_STATS_EN
        ,
        .stat_hits_o     (stat_hits_o),
        .stat_misses_o   (stat_misses_o),
        .stat_restarts_o (stat_restarts_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [31:0]      first;
        logic [31:0]      last;
        int               lat;
        logic             clr;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic        active = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          clr_total = 0;
    logic        clr_first = 1'b0;
    logic [63:0] mem [SIZE];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Range buffer model: one-cycle read latency, cleared by the invalidate strobe.
    always @(posedge clk) begin
        cyc++;
        if (req_valid_i && req_ready_o && rst_ni) acc_cyc = cyc;
        if (buf_rd_en_o) buf_rd_data_i <= mem[buf_rd_idx_o];
        if (buf_clr_o) mem[buf_clr_idx_o] <= 64'd0;
    end

    always @(negedge clk) begin
        if (!rst_ni) begin
            active = 1'b0;
        end else if (resp_valid_o) begin
            if (!active) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", resp_valid_o, 0);
                end else begin
                    cur = sb.pop_front();
                    active = 1'b1;
                    clr_total = 0;
                    clr_first = buf_clr_o;
                    chk("latency", cyc - acc_cyc, cur.lat);
                end
            end
            if (active) begin
                chk("resp_hit", resp_hit_o, cur.hit);
                chk("resp_idx", resp_idx_o, cur.idx);
                chk("resp_range", {resp_first_o, resp_last_o}, {cur.first, cur.last});
                chk("req_ready_in_resp", req_ready_o, 0);
                if (buf_clr_o) begin
                    clr_total++;
                    chk("clr_idx", buf_clr_idx_o, cur.idx);
                end
                if (resp_ready_i) begin
                    chk("clr_first_cycle", clr_first, cur.clr);
                    chk("clr_count", clr_total, cur.clr);
                    active = 1'b0;
                end
            end
        end else if (buf_clr_o) begin
            chk("stray_clr", buf_clr_o, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_table(input int i0, input logic [63:0] e0, input int i1, input logic [63:0] e1);
        for (int i = 0; i < SIZE; i++) mem[i] = 64'd0;
        if (i0 >= 0) mem[i0] = e0;
        if (i1 >= 0) mem[i1] = e1;
    endtask

    task automatic issue(input logic free, input logic [31:0] addr, input logic push,
                         input logic hit, input int idx, input logic [31:0] first,
                         input logic [31:0] last, input int lat);
        exp_t e;
        int   n;
        e.hit = hit; e.idx = IDX_W'(idx); e.first = first; e.last = last;
        e.lat = lat; e.clr = hit & free;
        if (push) sb.push_back(e);
        req_valid_i = 1'b1;
        req_free_i  = free;
        req_addr_i  = addr;
        n = 0;
        while (!req_ready_o && n < 50) begin tick(); n++; end
        chk("accept_timeout", n >= 50, 0);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || active) && n < 200) begin tick(); n++; end
        chk("resp_timeout", n >= 200, 0);
        tick();
    endtask

    task automatic lookup(input logic free, input logic [31:0] addr, input logic hit,
                          input int idx, input logic [31:0] first, input logic [31:0] last,
                          input int lat);
        issue(free, addr, 1'b1, hit, idx, first, last, lat);
        wait_done();
    endtask

    initial begin
        logic [2:0] quiet;
        int n;
        rst_ni = 1'b0; req_valid_i = 1'b0; req_free_i = 1'b0; req_addr_i = '0;
        buf_wr_seen_i = 1'b0; resp_ready_i = 1'b1; buf_rd_data_i = '0;
        set_table(-1, 0, -1, 0);
        repeat (3) tick();
        chk("reset_ctrl", {req_ready_o, buf_rd_en_o, buf_rd_idx_o, buf_clr_o, buf_clr_idx_o,
                           resp_valid_o, resp_hit_o, resp_idx_o}, 64'd0);
        chk("reset_data", {resp_first_o, resp_last_o}, 64'd0);
        rst_ni = 1'b1;
        tick();
        chk("idle_ready", req_ready_o, 1);

        set_table(2, {32'h1000, 32'h10FF}, -1, 0);
        lookup(0, 32'h1080, 1, 2, 32'h1000, 32'h10FF, 5);
        lookup(0, 32'h1100, 0, 0, 0, 0, 10);
        lookup(0, 32'h10FF, 1, 2, 32'h1000, 32'h10FF, 5);
        lookup(0, 32'h1000, 1, 2, 32'h1000, 32'h10FF, 5);
        lookup(0, 32'h0FFF, 0, 0, 0, 0, 10);

        set_table(1, {32'h2000, 32'h20FF}, 4, {32'h2000, 32'h2FFF});
        lookup(0, 32'h2010, 1, 1, 32'h2000, 32'h20FF, 4);
        lookup(0, 32'h2800, 1, 4, 32'h2000, 32'h2FFF, 7);

        set_table(3, {32'h3000, 32'h30FF}, -1, 0);
        lookup(1, 32'h3004, 0, 0, 0, 0, 10);
        lookup(1, 32'h3000, 1, 3, 32'h3000, 32'h30FF, 6);
        lookup(0, 32'h3010, 0, 0, 0, 0, 10);

        set_table(7, {32'h5000, 32'h5000}, -1, 0);
        lookup(0, 32'h5000, 1, 7, 32'h5000, 32'h5000, 10);

        // Restart: write seen in cycle 3, issue index returns to 0 in cycle 4.
        set_table(2, {32'h1000, 32'h10FF}, -1, 0);
        issue(0, 32'h1080, 1'b1, 1, 2, 32'h1000, 32'h10FF, 8);
        repeat (3) tick();
        buf_wr_seen_i = 1'b1;
        tick();
        buf_wr_seen_i = 1'b0;
        chk("restart_rd", {buf_rd_en_o, buf_rd_idx_o}, {1'b1, 3'd0});
        wait_done();
`ifdef RANGE_LOOKUP_STATS_EN
        chk("stat_restarts", stat_restarts_o, 1);
`endif

        // Response back-pressure.
        resp_ready_i = 1'b0;
        issue(0, 32'h1080, 1'b1, 1, 2, 32'h1000, 32'h10FF, 5);
        n = 0;
        while (!resp_valid_o && n < 50) begin tick(); n++; end
        chk("hold_wait_timeout", n >= 50, 0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rd_en", buf_rd_en_o, 0);
            tick();
        end
        resp_ready_i = 1'b1;
        wait_done();

        // Reset in the middle of a scan: no response, no clear.
        issue(1, 32'h1000, 1'b0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst_ni = 1'b0;
        #1;
        chk("midscan_reset_ctrl", {req_ready_o, buf_rd_en_o, buf_rd_idx_o, buf_clr_o,
                                   buf_clr_idx_o, resp_valid_o, resp_hit_o, resp_idx_o}, 64'd0);
        chk("midscan_reset_data", {resp_first_o, resp_last_o}, 64'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        quiet = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            quiet |= {resp_valid_o, buf_clr_o, buf_rd_en_o};
        end
        chk("post_reset_quiet", quiet, 0);
        chk("post_reset_ready", req_ready_o, 1);
        chk("post_reset_entry_kept", mem[2], {32'h1000, 32'h10FF});
        lookup(0, 32'h1080, 1, 2, 32'h1000, 32'h10FF, 5);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
